// File: rtl/hamming_checker.sv
// SECDED checker for a 16-bit word protected by a (21,16) Hamming code plus an
// overall parity bit. Two-stage pipeline: stage 1 registers the syndrome and
// overall-parity mismatch, stage 2 registers the corrected word and flags.
// Error counters and the alarm FSM consume the stage-2 outputs.
module hamming_checker #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [5:0]        parity_in,
    input  logic              clr_alarm,
    output logic              out_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              single_err,
    output logic              double_err,
    output logic [4:0]        err_pos,
    output logic [CNT_W-1:0]  sec_count,
    output logic [CNT_W-1:0]  ded_count,
    output logic [1:0]        alarm
);

    // Codeword position of each data bit (non-power-of-two slots, ascending).
    localparam logic [4:0] DATA_POS [16] = '{
        5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12,
        5'd13, 5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21
    };

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        AlOk   = 2'b00,
        AlDeg  = 2'b01,
        AlFail = 2'b11
    } alarm_e;

    logic [4:0]        syn;
    logic              ovr;
    logic              v1;
    logic [DATA_W-1:0] d1;
    logic [4:0]        s1;
    logic              om1;
    logic [DATA_W-1:0] fix;
    logic              se;
    logic              de;
    logic [4:0]        pos;
    alarm_e            alarm_q;

    // Syndrome is the XOR of the positions of all set bits (check bits sit at 2^k).
    always_comb begin
        syn = parity_in[4:0];
        ovr = ^{data_in, parity_in};
        for (int i = 0; i < 16; i++) begin
            if (data_in[i]) syn = syn ^ DATA_POS[i];
        end
    end

    // Stage 1: capture data, syndrome and overall mismatch for qualified words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1  <= 1'b0;
            d1  <= '0;
            s1  <= '0;
            om1 <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                d1  <= data_in;
                s1  <= syn;
                om1 <= ovr;
            end
        end
    end

    // Error classification and single-bit correction.
    always_comb begin
        fix = d1;
        se  = 1'b0;
        de  = 1'b0;
        pos = '0;
        if (v1) begin
            if (s1 == 5'd0) begin
                // Only the overall parity bit can be wrong here.
                se = om1;
            end else if (om1 && (s1 <= 5'd21)) begin
                se  = 1'b1;
                pos = s1;
                for (int i = 0; i < 16; i++) begin
                    if (DATA_POS[i] == s1) fix[i] = ~d1[i];
                end
            end else begin
                de  = 1'b1;
                pos = s1;
            end
        end
    end

    // Stage 2: registered outputs; flags are forced low on bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            data_out   <= '0;
            single_err <= 1'b0;
            double_err <= 1'b0;
            err_pos    <= '0;
        end else begin
            out_valid  <= v1;
            single_err <= se;
            double_err <= de;
            err_pos    <= pos;
            if (v1) data_out <= fix;
        end
    end

    // Saturating counters and alarm FSM; clear wins over a concurrent event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_count <= '0;
            ded_count <= '0;
            alarm_q   <= AlOk;
        end else if (clr_alarm) begin
            sec_count <= '0;
            ded_count <= '0;
            alarm_q   <= AlOk;
        end else if (out_valid) begin
            if (single_err && (sec_count != CNT_MAX)) sec_count <= sec_count + CNT_W'(1);
            if (double_err && (ded_count != CNT_MAX)) ded_count <= ded_count + CNT_W'(1);
            if (double_err) begin
                alarm_q <= AlFail;
            end else if (single_err && (alarm_q == AlOk)) begin
                alarm_q <= AlDeg;
            end
        end
    end

    assign alarm = alarm_q;

endmodule

// File: tb/tb_hamming_checker.sv
// Randomised and directed bench for hamming_checker against a codeword-level model.
module tb_hamming_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] data_in = '0;
    logic [5:0]  parity_in = '0;
    logic        clr_alarm = 1'b0;
    logic        out_valid;
    logic [15:0] data_out;
    logic        single_err;
    logic        double_err;
    logic [4:0]  err_pos;
    logic [7:0]  sec_count;
    logic [7:0]  ded_count;
    logic [1:0]  alarm;

    always #5 clk = ~clk;

    hamming_checker dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .parity_in  (parity_in),
        .clr_alarm  (clr_alarm),
        .out_valid  (out_valid),
        .data_out   (data_out),
        .single_err (single_err),
        .double_err (double_err),
        .err_pos    (err_pos),
        .sec_count  (sec_count),
        .ded_count  (ded_count),
        .alarm      (alarm)
    );

    typedef struct packed {
        logic        v;
        logic [15:0] d;
        logic        se;
        logic        de;
        logic [4:0]  pos;
    } exp_t;

    exp_t     pipe[$];
    exp_t     last_out = '0;
    int       total = 0;
    int       bad = 0;
    int       sec_m = 0;
    int       ded_m = 0;
    int       al_m = 0;
    int       vcount = 0;
    int       dpos[16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Reference: lay out the 21-bit codeword, syndrome = XOR of indices of set bits.
    function automatic exp_t model(input logic [15:0] d, input logic [5:0] p);
        logic cw [1:21];
        int   syn;
        logic om;
        exp_t e;
        for (int i = 1; i <= 21; i++) cw[i] = 1'b0;
        for (int k = 0; k < 5; k++) cw[1 << k] = p[k];
        for (int j = 0; j < 16; j++) cw[dpos[j]] = d[j];
        syn = 0;
        om  = p[5];
        for (int i = 1; i <= 21; i++) begin
            if (cw[i]) begin
                syn = syn ^ i;
                om  = ~om;
            end
        end
        e.v   = 1'b1;
        e.d   = d;
        e.se  = 1'b0;
        e.de  = 1'b0;
        e.pos = 5'(syn);
        if (syn == 0) begin
            e.se = om;
        end else if (om && syn <= 21) begin
            e.se = 1'b1;
            for (int j = 0; j < 16; j++) if (dpos[j] == syn) e.d[j] = ~e.d[j];
        end else begin
            e.de = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [5:0] encode(input logic [15:0] d);
        int p;
        p = 0;
        for (int j = 0; j < 16; j++) if (d[j]) p = p ^ dpos[j];
        encode[4:0] = 5'(p);
        encode[5]   = ^d ^ ^encode[4:0];
    endfunction

    // One clock: drive inputs, update counter/alarm model, check after the edge.
    task automatic tick(input logic v, input logic [15:0] d, input logic [5:0] p,
                        input logic clr);
        exp_t e;
        exp_t want;
        in_valid  = v;
        data_in   = d;
        parity_in = p;
        clr_alarm = clr;
        e = v ? model(d, p) : '0;
        pipe.push_back(e);
        if (clr) begin
            sec_m = 0;
            ded_m = 0;
            al_m  = 0;
        end else if (last_out.v) begin
            if (last_out.se) begin
                if (sec_m < 255) sec_m++;
                if (al_m == 0) al_m = 1;
            end
            if (last_out.de) begin
                if (ded_m < 255) ded_m++;
                al_m = 3;
            end
        end
        @(posedge clk);
        #1;
        want = (pipe.size() >= 2) ? pipe.pop_front() : '0;
        check("out_valid", out_valid, want.v);
        check("single_err", single_err, want.se);
        check("double_err", double_err, want.de);
        if (want.v) begin
            check("data_out", data_out, want.d);
            check("err_pos", err_pos, want.pos);
        end
        check("sec_count", sec_count, sec_m);
        check("ded_count", ded_count, ded_m);
        check("alarm", alarm, al_m);
        if (out_valid) vcount++;
        last_out = want;
    endtask

    task automatic idle();
        tick(1'b0, 16'h0, 6'h0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, data_out, 0);
        check({tag, "_se"}, single_err, 0);
        check({tag, "_de"}, double_err, 0);
        check({tag, "_pos"}, err_pos, 0);
        check({tag, "_sec"}, sec_count, 0);
        check({tag, "_ded"}, ded_count, 0);
        check({tag, "_alarm"}, alarm, 0);
    endtask

    // Asynchronous reset in the middle of a cycle; in-flight words are dropped.
    task automatic mid_reset();
        in_valid  = 1'b0;
        clr_alarm = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_zero("mid_rst");
        pipe.delete();
        last_out = '0;
        sec_m = 0;
        ded_m = 0;
        al_m  = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [21:0] w;
        int          r;
        int          b0;
        int          b1;
        int          n;

        n = 0;
        for (int pos = 1; pos <= 21; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                dpos[n] = pos;
                n++;
            end
        end

        #1 rst = 1'b0;
        #1 check_zero("reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // Clean word.
        tick(1'b1, 16'h0000, 6'h00, 1'b0);
        idle();
        check("clean_valid", out_valid, 1);
        check("clean_flags", {single_err, double_err}, 0);
        check("clean_alarm", alarm, 0);

        // Single data error at position 3.
        tick(1'b1, 16'h0001, 6'h00, 1'b0);
        idle();
        check("sec_data", data_out, 16'h0000);
        check("sec_pos", err_pos, 3);
        check("sec_flag", single_err, 1);
        idle();
        check("sec_cnt", sec_count, 1);
        check("sec_alarm", alarm, 2'b01);

        // Overall parity bit alone in error.
        tick(1'b1, 16'h0000, 6'h20, 1'b0);
        idle();
        check("op_flag", single_err, 1);
        check("op_pos", err_pos, 0);
        check("op_data", data_out, 16'h0000);

        // Double error, then a clean word: alarm stays failed.
        tick(1'b1, 16'h0003, 6'h00, 1'b0);
        idle();
        check("ded_flag", double_err, 1);
        check("ded_data", data_out, 16'h0003);
        tick(1'b1, 16'h0000, 6'h00, 1'b0);
        idle();
        check("ded_cnt", ded_count, 1);
        idle();
        check("ded_sticky", alarm, 2'b11);

        // Clear in the same cycle the error word is presented.
        tick(1'b1, 16'h0001, 6'h00, 1'b0);
        idle();
        check("clr_pre", single_err, 1);
        tick(1'b0, 16'h0, 6'h0, 1'b1);
        check("clr_sec", sec_count, 0);
        check("clr_ded", ded_count, 0);
        check("clr_alarm", alarm, 0);

        // Saturation with back-to-back single errors.
        vcount = 0;
        for (int i = 0; i < 300; i++) tick(1'b1, 16'h0001, 6'h00, 1'b0);
        idle();
        idle();
        idle();
        check("sat_sec", sec_count, 255);
        check("sat_valid", vcount, 300);

        // Reset with words in flight.
        tick(1'b1, 16'h1234, encode(16'h1234), 1'b0);
        tick(1'b1, 16'h0003, 6'h00, 1'b0);
        mid_reset();
        idle();
        idle();
        check("post_rst_stale", out_valid, 0);
        tick(1'b1, 16'hbeef, encode(16'hbeef), 1'b0);
        tick(1'b0, 16'h0, 6'h0, 1'b0);
        check("post_rst_lat", out_valid, 1);
        check("post_rst_data", data_out, 16'hbeef);

        // Random traffic with 0, 1, 2 injected flips or arbitrary parity.
        for (int i = 0; i < 600; i++) begin
            w[15:0]  = 16'($urandom);
            w[21:16] = encode(w[15:0]);
            r = $urandom_range(0, 9);
            if (r >= 4 && r <= 8) begin
                b0 = $urandom_range(0, 21);
                w[b0] = ~w[b0];
                if (r >= 7) begin
                    b1 = (b0 + 1 + $urandom_range(0, 20)) % 22;
                    w[b1] = ~w[b1];
                end
            end else if (r == 9) begin
                w[21:16] = 6'($urandom);
            end
            tick($urandom_range(0, 9) < 8, w[15:0], w[21:16], $urandom_range(0, 29) == 0);
        end
        idle();
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hamming_checker.md
HAMMING_CHECKER -- requirements
Module: hamming_checker

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, giving the protected data width; only 16 is supported.
REQ-002 The module SHALL have parameter CNT_W, default 8, giving the width of the error event counters.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: data_in/parity_in qualify this cycle.
REQ-006 Port data_in, input, 16 bits: received data word, d[0]..d[15].
REQ-007 Port parity_in, input, 6 bits: [4:0] Hamming check bits p0..p4; [5] overall parity bit.
REQ-008 Port clr_alarm, input, 1 bit: synchronous clear of alarm state and counters.
REQ-009 Port out_valid, output, 1 bit: data_out and flags qualify this cycle.
REQ-010 Port data_out, output, 16 bits: corrected data word.
REQ-011 Port single_err, output, 1 bit: a correctable error was detected in this word.
REQ-012 Port double_err, output, 1 bit: an uncorrectable error was detected in this word.
REQ-013 Port err_pos, output, 5 bits: syndrome value (codeword position 1..21); 0 when there is no error or when the overall parity bit is the one in error.
REQ-014 Port sec_count, output, CNT_W bits: saturating count of single-error words.
REQ-015 Port ded_count, output, CNT_W bits: saturating count of double-error words.
REQ-016 Port alarm, output, 2 bits: alarm state, encoded 00 OK, 01 DEGRADED, 11 FAILED.

Function
REQ-017 Codeword layout SHALL use positions 1..21: check bit pk at position 2^k (k=0..4); d[0]..d[15] fill the non-power-of-two positions 3,5,6,7,9..15,17..21 in ascending order.
REQ-018 Each pk SHALL be even parity over all positions whose index has bit k set; parity_in[5] SHALL be even parity over positions 1..21.
REQ-019 Stage 1 SHALL register the data, the 5-bit syndrome s and the overall mismatch flag om when in_valid=1; stage 2 SHALL register the outputs.
REQ-020 Latency SHALL be exactly 2 cycles: out_valid rises 2 cycles after in_valid, with no backpressure and throughput of 1 word per cycle.
REQ-021 The error decision SHALL be:
  - s=0, om=0: clean, flags 0.
  - s=0, om=1: single_err=1, err_pos=0, data unchanged.
  - s in 1..21, om=1: single_err=1, err_pos=s; data bit at position s is flipped if s is a data position.
  - s!=0, om=0, or s>21: double_err=1, data passed uncorrected.
REQ-022 single_err and double_err SHALL never both be 1; both SHALL be 0 whenever out_valid=0.
REQ-023 A counter SHALL increment by 1 on each out_valid cycle carrying its flag, and SHALL hold at 2^CNT_W-1 (saturation, no wrap).
REQ-024 Alarm FSM transitions:
  - OK to DEGRADED on single_err.
  - OK or DEGRADED to FAILED on double_err.
  - FAILED is sticky; DEGRADED never returns to OK except by clear.
REQ-025 clr_alarm=1 SHALL set alarm to OK and both counters to 0 on the next edge, taking priority over a simultaneous error event, which is discarded for counters and alarm.
REQ-026 Pipeline data flow SHALL be unaffected by clr_alarm.

Reset
REQ-027 On assertion of rst=0, the following SHALL clear immediately, without waiting for a clock edge: out_valid, data_out, single_err, double_err, err_pos, sec_count, ded_count, alarm=OK and both pipeline valid bits.
REQ-028 Words in flight when reset asserts SHALL be dropped; the first out_valid after rst deasserts SHALL occur 2 cycles after the first in_valid.

Verification
REQ-029 Scenario clean word: data_in=0x0000, parity_in=6'h00 -> 2 cycles later data_out=0x0000, flags 0, err_pos=0, alarm=00.
REQ-030 Scenario single data error: data_in=0x0001, parity_in=6'h00 -> data_out=0x0000, single_err=1, err_pos=3, sec_count=1, alarm=01.
REQ-031 Scenario double error: data_in=0x0003, parity_in=6'h00 -> data_out=0x0003, double_err=1, ded_count=1, alarm=11; a following clean word leaves alarm at 11.
REQ-032 Scenario overall parity bit error: data_in=0x0000, parity_in=6'h20 -> single_err=1, err_pos=0, data_out=0x0000.
REQ-033 Scenario saturation: 300 back-to-back single-error words with CNT_W=8 -> sec_count=255 and out_valid on each of the 300 cycles.
REQ-034 Scenario clear and reset: clr_alarm asserted in the same cycle as an error output -> counters=0 and alarm=00; rst asserted mid-stream -> all outputs 0 at once and no stale out_valid after release.
